// File: rtl/jcond_queue.sv
// jcond_queue: gathers resolved conditional-branch outcomes from several execute
// lanes each cycle. It emits them one per cycle, in program order, to the branch
// predictor update port. A small FIFO absorbs bursts. Outcomes that cannot fit are
// dropped and counted, so execute never stalls.
module jcond_queue #(
  parameter int XLEN   = 32,
  parameter int IN_NUM = 2,
  parameter int DEPTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [IN_NUM-1:0]         br_vld,
  input  logic [IN_NUM*XLEN-1:0]    br_pc,
  input  logic [IN_NUM-1:0]         br_hit,
  input  logic [IN_NUM-1:0]         br_satisfied,
  output logic                      jcond_vld,
  output logic [XLEN-1:0]           jcond_pc,
  output logic                      jcond_hit,
  output logic                      jcond_satisfied,
  output logic [$clog2(DEPTH):0]    q_level,
  output logic [7:0]                drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

  // Entry storage; contents are only meaningful between rd_ptr and wr_ptr
  logic [XLEN-1:0]  mem_pc  [DEPTH];
  logic             mem_hit [DEPTH];
  logic             mem_sat [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_ptr_nxt;
  logic [LVL_W-1:0] q_level_nxt;

  logic             pop;
  logic             byp_vld;
  logic [XLEN-1:0]  byp_pc;
  logic             byp_hit;
  logic             byp_sat;
  logic [IN_NUM-1:0] push_en;
  logic [PTR_W-1:0] push_addr [IN_NUM];
  logic [7:0]       drop_num;

  logic [LVL_W-1:0] occ;
  logic [PTR_W-1:0] wa;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // Decide this cycle's output source, which lanes are stored, and which are dropped
  always_comb begin
    pop     = (q_level != '0);
    byp_vld = 1'b0;
    byp_pc  = '0;
    byp_hit = 1'b0;
    byp_sat = 1'b0;
    push_en = '0;
    for (int i = 0; i < IN_NUM; i++) push_addr[i] = '0;
    drop_num = '0;
    // Occupancy after the head leaves; a pop at full frees a slot for this cycle's lanes
    occ = q_level - LVL_W'(pop);
    wa  = wr_ptr;
    for (int i = 0; i < IN_NUM; i++) begin
      if (br_vld[i]) begin
        if (!pop && !byp_vld) begin
          // Queue empty: the oldest valid lane goes straight to the output register
          byp_vld = 1'b1;
          byp_pc  = br_pc[i*XLEN +: XLEN];
          byp_hit = br_hit[i];
          byp_sat = br_satisfied[i];
        end else if (occ < DEPTH_L) begin
          push_en[i]   = 1'b1;
          push_addr[i] = wa;
          wa           = wa + 1'b1;
          occ          = occ + 1'b1;
        end else begin
          drop_num = drop_num + 1'b1;
        end
      end
    end
    wr_ptr_nxt  = wa;
    q_level_nxt = occ;
  end

  // Queue control, drop counter and the registered predictor update port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      q_level         <= '0;
      drop_cnt        <= '0;
      jcond_vld       <= 1'b0;
      jcond_pc        <= '0;
      jcond_hit       <= 1'b0;
      jcond_satisfied <= 1'b0;
    end else if (flush) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      q_level   <= '0;
      jcond_vld <= 1'b0;
    end else begin
      rd_ptr    <= rd_ptr + PTR_W'(pop);
      wr_ptr    <= wr_ptr_nxt;
      q_level   <= q_level_nxt;
      drop_cnt  <= sat_add8(drop_cnt, drop_num);
      jcond_vld <= pop | byp_vld;
      if (pop) begin
        jcond_pc        <= mem_pc[rd_ptr];
        jcond_hit       <= mem_hit[rd_ptr];
        jcond_satisfied <= mem_sat[rd_ptr];
      end else if (byp_vld) begin
        jcond_pc        <= byp_pc;
        jcond_hit       <= byp_hit;
        jcond_satisfied <= byp_sat;
      end
    end
  end

  // Entry storage writes; pointers alone track validity, so no reset is needed here
  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int i = 0; i < IN_NUM; i++) begin
        if (push_en[i]) begin
          mem_pc[push_addr[i]]  <= br_pc[i*XLEN +: XLEN];
          mem_hit[push_addr[i]] <= br_hit[i];
          mem_sat[push_addr[i]] <= br_satisfied[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_jcond_queue.sv
// Directed testbench for jcond_queue (XLEN=32, IN_NUM=2, DEPTH=8).
module tb_jcond_queue;

  localparam int XLEN   = 32;
  localparam int IN_NUM = 2;
  localparam int DEPTH  = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic [1:0]       br_vld = '0;
  logic [63:0]      br_pc = '0;
  logic [1:0]       br_hit = '0;
  logic [1:0]       br_satisfied = '0;
  logic             jcond_vld;
  logic [31:0]      jcond_pc;
  logic             jcond_hit;
  logic             jcond_satisfied;
  logic [3:0]       q_level;
  logic [7:0]       drop_cnt;

  int checks = 0;
  int errors = 0;

  jcond_queue #(.XLEN(XLEN), .IN_NUM(IN_NUM), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .br_vld(br_vld), .br_pc(br_pc), .br_hit(br_hit), .br_satisfied(br_satisfied),
    .jcond_vld(jcond_vld), .jcond_pc(jcond_pc), .jcond_hit(jcond_hit),
    .jcond_satisfied(jcond_satisfied), .q_level(q_level), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic idle_lanes();
    br_vld = '0; br_pc = '0; br_hit = '0; br_satisfied = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_lanes();
    #12;
    checks++;
    if ({jcond_vld, jcond_pc, jcond_hit, jcond_satisfied} !== 35'h0) begin
      errors++; $display("FAIL reset_out got %h want 0", {jcond_vld, jcond_pc, jcond_hit, jcond_satisfied});
    end
    checks++;
    if (q_level !== 4'd0 || drop_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_ctrl got q=%0d d=%0d want 0/0", q_level, drop_cnt);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_bypass();
    @(negedge clk);
    br_vld = 2'b01; br_pc = {32'h0, 32'h100}; br_hit = 2'b00; br_satisfied = 2'b01;
    @(posedge clk); #1;
    checks++;
    if ({jcond_vld, jcond_pc, jcond_hit, jcond_satisfied, q_level} !== {1'b1, 32'h100, 1'b0, 1'b1, 4'd0}) begin
      errors++; $display("FAIL bypass got vld=%b pc=%h hit=%b sat=%b q=%0d want 1/100/0/1/0",
                         jcond_vld, jcond_pc, jcond_hit, jcond_satisfied, q_level);
    end
    @(negedge clk); idle_lanes();
    @(posedge clk); #1;
    checks++;
    if (jcond_vld !== 1'b0) begin
      errors++; $display("FAIL bypass_end got vld=%b want 0", jcond_vld);
    end
  endtask

  task automatic test_two_lanes();
    @(negedge clk);
    br_vld = 2'b11; br_pc = {32'h204, 32'h200}; br_hit = 2'b01; br_satisfied = 2'b10;
    @(posedge clk); #1;
    checks++;
    if ({jcond_vld, jcond_pc, jcond_hit, jcond_satisfied, q_level} !== {1'b1, 32'h200, 1'b1, 1'b0, 4'd1}) begin
      errors++; $display("FAIL two_lane0 got vld=%b pc=%h hit=%b sat=%b q=%0d want 1/200/1/0/1",
                         jcond_vld, jcond_pc, jcond_hit, jcond_satisfied, q_level);
    end
    @(negedge clk); idle_lanes();
    @(posedge clk); #1;
    checks++;
    if ({jcond_vld, jcond_pc, jcond_hit, jcond_satisfied, q_level} !== {1'b1, 32'h204, 1'b0, 1'b1, 4'd0}) begin
      errors++; $display("FAIL two_lane1 got vld=%b pc=%h hit=%b sat=%b q=%0d want 1/204/0/1/0",
                         jcond_vld, jcond_pc, jcond_hit, jcond_satisfied, q_level);
    end
    @(posedge clk); #1;
    checks++;
    if (jcond_vld !== 1'b0) begin
      errors++; $display("FAIL two_lane_end got vld=%b want 0", jcond_vld);
    end
  endtask

  task automatic test_lane1_only();
    @(negedge clk);
    br_vld = 2'b10; br_pc = {32'h300, 32'hDEAD}; br_hit = 2'b10; br_satisfied = 2'b00;
    @(posedge clk); #1;
    checks++;
    if ({jcond_vld, jcond_pc, jcond_hit, jcond_satisfied, q_level} !== {1'b1, 32'h300, 1'b1, 1'b0, 4'd0}) begin
      errors++; $display("FAIL lane1_only got vld=%b pc=%h hit=%b sat=%b q=%0d want 1/300/1/0/0",
                         jcond_vld, jcond_pc, jcond_hit, jcond_satisfied, q_level);
    end
    @(negedge clk); idle_lanes();
    @(posedge clk); #1;
    checks++;
    if (jcond_vld !== 1'b0) begin
      errors++; $display("FAIL lane1_end got vld=%b want 0", jcond_vld);
    end
  endtask

  // Both lanes every cycle for 12 cycles; lane 1 of cycles 9..12 finds no room.
  task automatic test_burst();
    logic [33:0] exp_q[$];
    logic [33:0] exp;
    logic [31:0] pa;
    logic        h;
    int          lvl;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      pa = 32'h1000 + 32'(8 * (k - 1));
      h  = k[0];
      br_vld = 2'b11; br_pc = {pa + 32'h4, pa}; br_hit = {1'b0, h}; br_satisfied = 2'b10;
      exp_q.push_back({pa, h, 1'b0});
      if (k < 9) exp_q.push_back({pa + 32'h4, 1'b0, 1'b1});
      @(posedge clk); #1;
      exp = exp_q.pop_front();
      lvl = (k < 8) ? k : 8;
      checks++;
      if ({jcond_vld, jcond_pc, jcond_hit, jcond_satisfied} !== {1'b1, exp}) begin
        errors++; $display("FAIL burst_out[%0d] got vld=%b pc=%h hit=%b sat=%b want pc=%h hit=%b sat=%b",
                           k, jcond_vld, jcond_pc, jcond_hit, jcond_satisfied, exp[33:2], exp[1], exp[0]);
      end
      checks++;
      if (q_level !== 4'(lvl)) begin
        errors++; $display("FAIL burst_level[%0d] got %0d want %0d", k, q_level, lvl);
      end
    end
    @(negedge clk); idle_lanes();
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      exp = exp_q.pop_front();
      checks++;
      if ({jcond_vld, jcond_pc, jcond_hit, jcond_satisfied, q_level} !== {1'b1, exp, 4'(7 - k)}) begin
        errors++; $display("FAIL drain[%0d] got vld=%b pc=%h q=%0d want pc=%h q=%0d",
                           k, jcond_vld, jcond_pc, q_level, exp[33:2], 7 - k);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (jcond_vld !== 1'b0 || drop_cnt !== 8'd4) begin
      errors++; $display("FAIL burst_end got vld=%b drop=%0d want 0/4", jcond_vld, drop_cnt);
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      br_vld = 2'b11; br_pc = {32'h2004 + 32'(8 * k), 32'h2000 + 32'(8 * k)};
      @(posedge clk);
    end
    #1;
    checks++;
    if (q_level !== 4'd5) begin
      errors++; $display("FAIL flush_pre got q=%0d want 5", q_level);
    end
    @(negedge clk);
    flush = 1'b1; br_vld = 2'b11; br_pc = {32'h2F04, 32'h2F00};
    @(posedge clk); #1;
    checks++;
    if (jcond_vld !== 1'b0 || q_level !== 4'd0 || drop_cnt !== 8'd4) begin
      errors++; $display("FAIL flush got vld=%b q=%0d drop=%0d want 0/0/4", jcond_vld, q_level, drop_cnt);
    end
    @(negedge clk); flush = 1'b0; idle_lanes();
    @(posedge clk); #1;
    checks++;
    if (jcond_vld !== 1'b0 || q_level !== 4'd0) begin
      errors++; $display("FAIL flush_after got vld=%b q=%0d want 0/0", jcond_vld, q_level);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      br_vld = 2'b11; br_pc = {32'h3004 + 32'(8 * k), 32'h3000 + 32'(8 * k)}; br_hit = 2'b11; br_satisfied = 2'b11;
      @(posedge clk);
    end
    #1;
    checks++;
    if (q_level !== 4'd6 || jcond_vld !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre got q=%0d vld=%b want 6/1", q_level, jcond_vld);
    end
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({jcond_vld, jcond_pc, jcond_hit, jcond_satisfied, q_level, drop_cnt} !== 47'h0) begin
      errors++; $display("FAIL rstmid_async got vld=%b pc=%h hit=%b sat=%b q=%0d drop=%0d want all 0",
                         jcond_vld, jcond_pc, jcond_hit, jcond_satisfied, q_level, drop_cnt);
    end
    @(posedge clk); #1;
    checks++;
    if ({jcond_vld, q_level} !== 5'h0) begin
      errors++; $display("FAIL rstmid_hold got vld=%b q=%0d want 0/0", jcond_vld, q_level);
    end
    @(negedge clk); idle_lanes(); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (jcond_vld !== 1'b0) begin
      errors++; $display("FAIL rstmid_release got vld=%b want 0", jcond_vld);
    end
    @(negedge clk); br_vld = 2'b01; br_pc = {32'h0, 32'h400};
    @(posedge clk); #1;
    checks++;
    if ({jcond_vld, jcond_pc, jcond_hit, jcond_satisfied} !== {1'b1, 32'h400, 1'b0, 1'b0}) begin
      errors++; $display("FAIL rstmid_new got vld=%b pc=%h hit=%b sat=%b want 1/400/0/0",
                         jcond_vld, jcond_pc, jcond_hit, jcond_satisfied);
    end
    @(negedge clk); idle_lanes();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (jcond_vld !== 1'b0 || q_level !== 4'd0) begin
        errors++; $display("FAIL rstmid_tail[%0d] got vld=%b q=%0d want 0/0", k, jcond_vld, q_level);
      end
    end
  endtask

  // From an empty queue, cycle k (k>=9) drops exactly one lane.
  task automatic test_saturation();
    for (int k = 1; k <= 270; k++) begin
      @(negedge clk);
      br_vld = 2'b11; br_pc = {32'h5004, 32'h5000};
      @(posedge clk); #1;
      if (k == 100) begin
        checks++;
        if (drop_cnt !== 8'd92) begin
          errors++; $display("FAIL sat_mid got %0d want 92", drop_cnt);
        end
      end
    end
    checks++;
    if (drop_cnt !== 8'd255 || q_level !== 4'd8) begin
      errors++; $display("FAIL sat_end got drop=%0d q=%0d want 255/8", drop_cnt, q_level);
    end
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (drop_cnt !== 8'd255 || jcond_vld !== 1'b0 || q_level !== 4'd0) begin
      errors++; $display("FAIL sat_flush got drop=%0d vld=%b q=%0d want 255/0/0", drop_cnt, jcond_vld, q_level);
    end
    @(negedge clk); flush = 1'b0; idle_lanes();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_two_lanes();
    test_lane1_only();
    test_burst();
    test_flush();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
